// File: rtl/pic_prog_loader.sv
// Byte-stream program loader for the PIC core's writable program memory.
// Parses a framed packet (header, address, count, data pairs, checksum).
// Writes each 12-bit instruction word with a single write-strobe cycle.
// Holds the core in reset while a load is in progress, pulses done when a
// load succeeds and keeps error raised after a failed load.
module pic_prog_loader #(
  parameter logic [7:0] HEADER  = 8'hA5,
  parameter int         ADDR_W  = 9,
  parameter int         DATA_W  = 12,
  parameter int         TIMEOUT = 1023
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              core_hold,
  output logic              done,
  output logic              error,
  output logic [9:0]        words_loaded,
  output logic [3:0]        state_dbg
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    ADDR_LO = 4'd1,
    ADDR_HI = 4'd2,
    CNT_LO  = 4'd3,
    CNT_HI  = 4'd4,
    DATA_LO = 4'd5,
    DATA_HI = 4'd6,
    CHECK   = 4'd7,
    DONE    = 4'd8,
    ERR     = 4'd9
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   maddr_q, maddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                we_q, we_d;
  logic [9:0]          cnt_q, cnt_d;
  logic [9:0]          words_q, words_d;
  logic [7:0]          chk_q, chk_d;
  logic [7:0]          lo_q, lo_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic                alive_q;
  logic                accept;
  logic                active;
  logic [9:0]          cnt_full;

  // Handshake: a byte transfers on a rising clock edge where in_valid and
  // in_ready are both high; in_ready depends only on registered state, so
  // the source may hold in_valid/in_data until it sees the transfer.
  assign accept   = in_valid & in_ready;
  assign active   = state_q inside {ADDR_LO, ADDR_HI, CNT_LO, CNT_HI,
                                    DATA_LO, DATA_HI, CHECK};
  assign cnt_full = {in_data[1:0], cnt_q[7:0]};

  // Next-state, datapath and timeout logic.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    maddr_d = maddr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    cnt_d   = cnt_q;
    words_d = words_q;
    chk_d   = chk_q;
    lo_d    = lo_q;
    tmo_d   = tmo_q;

    // Idle-gap watchdog inside a packet; any accepted byte restarts it.
    if (active) begin
      if (accept) begin
        tmo_d = '0;
      end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
        state_d = ERR;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end

    case (state_q)
      IDLE, ERR: begin
        if (accept && in_data == HEADER) begin
          state_d = ADDR_LO;
          chk_d   = '0;
          words_d = '0;
          tmo_d   = '0;
        end
      end
      ADDR_LO: begin
        if (accept) begin
          addr_d[7:0] = in_data;
          chk_d       = chk_q + in_data;
          state_d     = ADDR_HI;
        end
      end
      ADDR_HI: begin
        if (accept) begin
          addr_d[ADDR_W-1] = in_data[0];
          chk_d            = chk_q + in_data;
          state_d          = CNT_LO;
        end
      end
      CNT_LO: begin
        if (accept) begin
          cnt_d   = {2'b00, in_data};
          chk_d   = chk_q + in_data;
          state_d = CNT_HI;
        end
      end
      CNT_HI: begin
        if (accept) begin
          cnt_d   = cnt_full;
          chk_d   = chk_q + in_data;
          state_d = (cnt_full == 10'd0 || cnt_full > 10'd512) ? ERR : DATA_LO;
        end
      end
      DATA_LO: begin
        if (accept) begin
          lo_d    = in_data;
          chk_d   = chk_q + in_data;
          state_d = DATA_HI;
        end
      end
      DATA_HI: begin
        // Word is presented to memory on the next cycle; address and
        // counters advance now so the following byte can arrive back-to-back.
        if (accept) begin
          we_d    = 1'b1;
          wdata_d = {in_data[3:0], lo_q};
          maddr_d = addr_q;
          addr_d  = addr_q + 1'b1;
          words_d = words_q + 1'b1;
          cnt_d   = cnt_q - 1'b1;
          chk_d   = chk_q + in_data;
          state_d = (cnt_q == 10'd1) ? CHECK : DATA_LO;
        end
      end
      CHECK: begin
        if (accept) begin
          state_d = (in_data == chk_q) ? DONE : ERR;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any partial packet.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      maddr_q <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      cnt_q   <= '0;
      words_q <= '0;
      chk_q   <= '0;
      lo_q    <= '0;
      tmo_q   <= '0;
      alive_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      maddr_q <= maddr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
      words_q <= words_d;
      chk_q   <= chk_d;
      lo_q    <= lo_d;
      tmo_q   <= tmo_d;
      alive_q <= 1'b1;
    end
  end

  // Outputs are decoded from registers so they drop as soon as reset asserts.
  assign in_ready     = alive_q && (state_q != DONE);
  assign mem_we       = we_q;
  assign mem_addr     = maddr_q;
  assign mem_wdata    = wdata_q;
  assign core_hold    = (state_q != IDLE) && (state_q != DONE);
  assign done         = (state_q == DONE);
  assign error        = (state_q == ERR);
  assign words_loaded = words_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_pic_prog_loader.sv
// Self-checking bench for pic_prog_loader: table of packets with expected
// writes and end status, plus hand-written timeout and mid-packet reset runs.
module tb_pic_prog_loader;

  localparam int TMO = 1023;

  logic        clock;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        mem_we;
  logic [8:0]  mem_addr;
  logic [11:0] mem_wdata;
  logic        core_hold;
  logic        done;
  logic        error;
  logic [9:0]  words_loaded;
  logic [3:0]  state_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  logic [20:0] exp_q[$];

  typedef struct {
    logic [7:0]  b [12];
    int          n;
    int          nw;
    logic [20:0] w [2];
    logic        exp_done;
    logic        exp_err;
    logic        exp_hold;
    logic [9:0]  exp_words;
  } vec_t;

  vec_t vecs [7];

  pic_prog_loader dut (
    .clock        (clock),
    .reset        (reset),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .core_hold    (core_hold),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded),
    .state_dbg    (state_dbg)
  );

  // Clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog act=timeout req=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s act=%0h req=%0h", name, act, req);
    end
  endfunction

  // Scoreboard: every write strobe must match the head of the expected queue.
  always @(negedge clock) begin
    if (mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write act=%h@%h req=none", mem_wdata, mem_addr);
      end else begin
        check("write", 32'({mem_addr, mem_wdata}), 32'(exp_q.pop_front()));
      end
    end
    if (done === 1'b1) begin
      done_cnt++;
      check("hold_at_done", 32'(core_hold), 32'(0));
    end
  end

  // Driver
  task automatic send_byte(input logic [7:0] b);
    int guard = 0;
    @(negedge clock);
    in_data  = b;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && guard < 20) begin
      @(negedge clock);
      guard++;
    end
    if (in_ready !== 1'b1) begin
      check("ready_wait", 32'(in_ready), 32'(1));
    end
    @(posedge clock);
    #1 in_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  32'(in_ready), 32'(0));
    check({tag, "_mem_we"},    32'(mem_we), 32'(0));
    check({tag, "_mem_addr"},  32'(mem_addr), 32'(0));
    check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'(0));
    check({tag, "_core_hold"}, 32'(core_hold), 32'(0));
    check({tag, "_done"},      32'(done), 32'(0));
    check({tag, "_error"},     32'(error), 32'(0));
    check({tag, "_words"},     32'(words_loaded), 32'(0));
  endtask

  initial begin
    logic [7:0] rp [14];

    // Packet table: bytes, expected writes {addr, data}, final status.
    vecs[0].b = '{8'hA5, 8'h10, 8'h00, 8'h02, 8'h00, 8'h34, 8'h12, 8'h78,
                  8'h06, 8'hD6, 8'h00, 8'h00};
    vecs[0].n = 10; vecs[0].nw = 2;
    vecs[0].w = '{21'h010234, 21'h011678};
    vecs[0].exp_done = 1; vecs[0].exp_err = 0; vecs[0].exp_hold = 0;
    vecs[0].exp_words = 10'd2;

    vecs[1] = vecs[0];
    vecs[1].b[9] = 8'hD7;
    vecs[1].exp_done = 0; vecs[1].exp_err = 1; vecs[1].exp_hold = 1;

    vecs[2] = vecs[0];

    // Address 0x1FF with ignored upper bits set in ADDR_HI and DATA_HI.
    vecs[3].b = '{8'hA5, 8'hFF, 8'hFF, 8'h02, 8'h00, 8'hAB, 8'hFC, 8'hCD,
                  8'h0E, 8'h82, 8'h00, 8'h00};
    vecs[3].n = 10; vecs[3].nw = 2;
    vecs[3].w = '{21'h1FFCAB, 21'h000ECD};
    vecs[3].exp_done = 1; vecs[3].exp_err = 0; vecs[3].exp_hold = 0;
    vecs[3].exp_words = 10'd2;

    vecs[4].b = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                  8'h00, 8'h00, 8'h00, 8'h00};
    vecs[4].n = 5; vecs[4].nw = 0;
    vecs[4].w = '{21'h0, 21'h0};
    vecs[4].exp_done = 0; vecs[4].exp_err = 1; vecs[4].exp_hold = 1;
    vecs[4].exp_words = 10'd0;

    vecs[5] = vecs[4];
    vecs[5].b[3] = 8'h01;
    vecs[5].b[4] = 8'h02;

    // Leading garbage before the header is discarded.
    vecs[6].b = '{8'h00, 8'hFF, 8'hA5, 8'h10, 8'h00, 8'h02, 8'h00, 8'h34,
                  8'h12, 8'h78, 8'h06, 8'hD6};
    vecs[6].n = 12; vecs[6].nw = 2;
    vecs[6].w = '{21'h010234, 21'h011678};
    vecs[6].exp_done = 1; vecs[6].exp_err = 0; vecs[6].exp_hold = 0;
    vecs[6].exp_words = 10'd2;

    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    #3 reset = 1'b0;
    #1 check_reset_outputs("reset");
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("ready_after_reset", 32'(in_ready), 32'(1));

    for (int v = 0; v < 7; v++) begin
      done_cnt = 0;
      for (int k = 0; k < vecs[v].nw; k++) exp_q.push_back(vecs[v].w[k]);
      for (int i = 0; i < vecs[v].n; i++) begin
        send_byte(vecs[v].b[i]);
        if (vecs[v].b[i] == 8'hA5 && i < 3) begin
          @(negedge clock);
          check($sformatf("v%0d_hold_after_hdr", v), 32'(core_hold), 32'(1));
        end
      end
      repeat (2) @(negedge clock);
      check($sformatf("v%0d_done_cnt", v), 32'(done_cnt), 32'(vecs[v].exp_done));
      check($sformatf("v%0d_error", v), 32'(error), 32'(vecs[v].exp_err));
      check($sformatf("v%0d_hold", v), 32'(core_hold), 32'(vecs[v].exp_hold));
      check($sformatf("v%0d_words", v), 32'(words_loaded), 32'(vecs[v].exp_words));
      check($sformatf("v%0d_pending", v), 32'(exp_q.size()), 32'(0));
    end

    // Timeout: stall after DATA_LO; error rises on exactly the TMO-th idle edge.
    done_cnt = 0;
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h11);
    repeat (TMO - 1) @(posedge clock);
    @(negedge clock);
    check("tmo_error_before", 32'(error), 32'(0));
    @(posedge clock);
    @(negedge clock);
    check("tmo_error_at", 32'(error), 32'(1));
    check("tmo_hold", 32'(core_hold), 32'(1));
    repeat (5) @(negedge clock);
    check("tmo_words", 32'(words_loaded), 32'(0));
    check("tmo_done", 32'(done_cnt), 32'(0));

    // Reset between words of a 4-word packet, then a full reload.
    exp_q.push_back(21'h020101);
    exp_q.push_back(21'h021202);
    send_byte(8'hA5); send_byte(8'h20); send_byte(8'h00);
    send_byte(8'h04); send_byte(8'h00);
    send_byte(8'h01); send_byte(8'h01);
    send_byte(8'h02); send_byte(8'h02);
    @(negedge clock);
    check("mid_words", 32'(words_loaded), 32'(2));
    #2 reset = 1'b0;
    #1 check_reset_outputs("midrst");
    repeat (3) @(negedge clock);
    check("midrst_pending", 32'(exp_q.size()), 32'(0));
    reset = 1'b1;

    done_cnt = 0;
    rp = '{8'hA5, 8'h20, 8'h00, 8'h04, 8'h00, 8'h01, 8'h01, 8'h02,
           8'h02, 8'h03, 8'h03, 8'h04, 8'h04, 8'h38};
    exp_q.push_back(21'h020101);
    exp_q.push_back(21'h021202);
    exp_q.push_back(21'h022303);
    exp_q.push_back(21'h023404);
    for (int i = 0; i < 14; i++) send_byte(rp[i]);
    repeat (2) @(negedge clock);
    check("reload_done", 32'(done_cnt), 32'(1));
    check("reload_error", 32'(error), 32'(0));
    check("reload_hold", 32'(core_hold), 32'(0));
    check("reload_words", 32'(words_loaded), 32'(4));
    check("reload_pending", 32'(exp_q.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
